axis_frame_generator: RTL
=========================

// Module: axis_frame_generator
// PURPOSE
//  AXI-Stream transmitter (master end of the AXI_STREAM_BUS valid/last/data/ready link).
//  Emits frames of programmable length with an incrementing data pattern and marks the final beat with last.
//  Honours ready backpressure.
//  Drives the s_axis input of stream consumers and serves as a traffic source for link bring-up.
// PARAMETERS
//  DATA_WIDTH  32  width of m_axis_data; pattern arithmetic is modulo 2**DATA_WIDTH
//  LEN_WIDTH   16  width of frame_len (beats per frame, 1..2**LEN_WIDTH-1)
//  GAP_WIDTH    8  width of gap_len (present only with AXIS_FRAME_GEN_GAP_EN)
// PORTS
//  s_axis_clk     in   1           single clock, all logic on rising edge
//  s_axis_resetn  in   1           asynchronous active-low reset
//  start          in   1           frame request, sampled only in IDLE
//  frame_len      in   LEN_WIDTH   beats per frame, latched on accepted start
//  seed           in   DATA_WIDTH  data of first beat, latched on accepted start
//  continuous     in   1           1: auto-restart after each frame; sampled at the last handshake
//  gap_len        in   GAP_WIDTH   idle cycles between frames (AXIS_FRAME_GEN_GAP_EN only)
//  m_axis_valid   out  1           beat valid
//  m_axis_last    out  1           final beat of frame
//  m_axis_data    out  DATA_WIDTH  beat payload
//  m_axis_ready   in   1           sink ready
//  busy           out  1           1 in any state other than IDLE
//  frame_done     out  1           one-cycle pulse after the last-beat handshake
//  frame_cnt      out  16          completed frames, wraps 0xFFFF->0
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE.
//   All outputs 0: valid, last, data, busy, frame_done, frame_cnt.
//   A reset mid-frame abandons the frame; no partial last is emitted.
//  Handshake: a beat transfers on the edge where valid&ready=1.
//   While valid&!ready: data and last are held stable and valid never drops.
//   valid does not depend combinationally on ready; all outputs are registered.
//  FSM states: IDLE, SEND, GAP (GAP exists only with the macro).
//   IDLE->SEND: on the edge where start=1 and frame_len!=0. Latch frame_len and seed.
//     m_axis_valid=1 with data=seed on the following cycle (1-cycle latency).
//   start with frame_len==0: ignored; stay IDLE; no output activity.
//   start in SEND/GAP: ignored. frame_len/seed changes mid-frame: no effect.
//   SEND: beat k (0-based) carries seed+k (wraps). last=1 only on beat frame_len-1.
//     frame_len==1: first beat has last=1.
//   On the last-beat handshake: frame_done=1 next cycle; frame_cnt+=1.
//     Then if continuous=1: next frame starts with seed = previous last data + 1 and the same latched length.
//       With no gap, valid stays high with no bubble.
//     If continuous=0: ->IDLE, valid=0.
//   start=1 on the same edge as the last-beat handshake is ignored; the generator re-arms in IDLE next cycle.
//  Beat counter is LEN_WIDTH wide and resets to 0 per frame; it never wraps within a frame.
// CONFIGURATION
//  AXIS_FRAME_GEN_GAP_EN defined:
//   After each frame, with continuous=1 and gap_len!=0: SEND->GAP.
//   valid=0 for exactly gap_len cycles, then ->SEND. gap_len is sampled at the last-beat handshake.
//   gap_len=0 behaves as back-to-back.
//  AXIS_FRAME_GEN_GAP_EN undefined:
//   gap_len port and GAP state are absent; continuous frames are always back-to-back.
// TESTING
//  1. Reset release, then start with len=4, seed=0x0A1B2C3D, ready=1.
//     -> data 0x0A1B2C3D..0x0A1B2C40 on 4 consecutive cycles; last on beat 3.
//     -> frame_done pulse; frame_cnt=1; busy low afterwards.
//  2. len=3, seed=0xFFFFFFFE.
//     -> data 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000 (wrap); last on the 3rd beat.
//  3. ready toggled 1010..., len=5.
//     -> each beat held stable while ready=0; exactly 5 handshakes; valid never drops mid-frame.
//  4. continuous=1, len=2, seed=0x10, 3 frames.
//     -> data 0x10,0x11 | 0x12,0x13 | 0x14,0x15 with no bubble; last on every 2nd beat; frame_cnt=3.
//  5. frame_len=0 with start -> no valid, busy=0.
//     Resetn pulsed low on beat 2 of an 8-beat frame -> valid=0 immediately; frame_cnt=0.
//  6. (GAP_EN) continuous=1, gap_len=3, len=2 -> exactly 3 idle valid=0 cycles between frames.

Source files
------------

// File: rtl/axis_frame_generator.sv
// AXI-Stream frame source: programmable-length frames with an incrementing data pattern.
// Optional inter-frame gap support is enabled by defining AXIS_FRAME_GEN_GAP_EN.
module axis_frame_generator #(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 16
`ifdef AXIS_FRAME_GEN_GAP_EN
    ,
    parameter int GAP_WIDTH  = 8
`endif
) (
    input  logic                  s_axis_clk,
    input  logic                  s_axis_resetn,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  frame_len,
    input  logic [DATA_WIDTH-1:0] seed,
    input  logic                  continuous,
`ifdef AXIS_FRAME_GEN_GAP_EN
    input  logic [GAP_WIDTH-1:0]  gap_len,
`endif
    output logic                  m_axis_valid,
    output logic                  m_axis_last,
    output logic [DATA_WIDTH-1:0] m_axis_data,
    input  logic                  m_axis_ready,
    output logic                  busy,
    output logic                  frame_done,
    output logic [15:0]           frame_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1
`ifdef AXIS_FRAME_GEN_GAP_EN
        ,
        GAP  = 2'd2
`endif
    } state_t;

    state_t                state_q, state_d;
    logic                  valid_q, valid_d;
    logic                  last_q, last_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [LEN_WIDTH-1:0]  beat_q, beat_d;
    logic                  done_q, done_d;
    logic [15:0]           cnt_q, cnt_d;
`ifdef AXIS_FRAME_GEN_GAP_EN
    logic [GAP_WIDTH-1:0]  gap_q, gap_d;
`endif

    logic handshake;
    logic single_beat;

    assign handshake   = valid_q & m_axis_ready;
    assign single_beat = (len_q == LEN_WIDTH'(1));

    // NOTE: every variable gets its hold value first so no path through the case infers a latch.
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        last_d  = last_q;
        data_d  = data_q;
        len_d   = len_q;
        beat_d  = beat_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
`ifdef AXIS_FRAME_GEN_GAP_EN
        gap_d   = gap_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start && (frame_len != '0)) begin
                    state_d = SEND;
                    valid_d = 1'b1;
                    data_d  = seed;
                    len_d   = frame_len;
                    beat_d  = '0;
                    last_d  = (frame_len == LEN_WIDTH'(1));
                end
            end
            SEND: begin
                if (handshake) begin
                    if (last_q) begin
                        done_d = 1'b1;
                        cnt_d  = cnt_q + 16'd1;
                        beat_d = '0;
                        if (!continuous) begin
                            state_d = IDLE;
                            valid_d = 1'b0;
                            last_d  = 1'b0;
`ifdef AXIS_FRAME_GEN_GAP_EN
                        end else if (gap_len != '0) begin
                            state_d = GAP;
                            valid_d = 1'b0;
                            last_d  = 1'b0;
                            gap_d   = gap_len;
`endif
                        end else begin
                            // Back-to-back restart: the next frame continues the pattern without a bubble.
                            data_d = data_q + DATA_WIDTH'(1);
                            last_d = single_beat;
                        end
                    end else begin
                        data_d = data_q + DATA_WIDTH'(1);
                        beat_d = beat_q + LEN_WIDTH'(1);
                        last_d = ((beat_q + LEN_WIDTH'(1)) == (len_q - LEN_WIDTH'(1)));
                    end
                end
            end
`ifdef AXIS_FRAME_GEN_GAP_EN
            GAP: begin
                if (gap_q == GAP_WIDTH'(1)) begin
                    state_d = SEND;
                    valid_d = 1'b1;
                    data_d  = data_q + DATA_WIDTH'(1);
                    last_d  = single_beat;
                end else begin
                    gap_d = gap_q - GAP_WIDTH'(1);
                end
            end
`endif
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                last_d  = 1'b0;
            end
        endcase
    end

    // NOTE: all state, including the latched length and seed-derived data, is cleared by the async reset so outputs are 0 immediately.
    always_ff @(posedge s_axis_clk or negedge s_axis_resetn) begin
        if (!s_axis_resetn) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= '0;
            len_q   <= '0;
            beat_q  <= '0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
`ifdef AXIS_FRAME_GEN_GAP_EN
            gap_q   <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            data_q  <= data_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
`ifdef AXIS_FRAME_GEN_GAP_EN
            gap_q   <= gap_d;
`endif
        end
    end

    assign m_axis_valid = valid_q;
    assign m_axis_last  = last_q;
    assign m_axis_data  = data_q;
    assign busy         = (state_q != IDLE);
    assign frame_done   = done_q;
    assign frame_cnt    = cnt_q;

endmodule
